yarp_mem_arb: RTL and testbench

- Shares the single memory port of the YARP core between instruction fetch and the load/store path (data_req/data_wr/data_byte from the control unit).
- Arbitrates, registers the winning request onto the memory bus with a req/gnt handshake, and tracks one outstanding transaction.
- Routes the response back to its owner.
- Sits between the fetch unit / data-memory interface and the external memory.

---
 rtl/yarp_mem_arb_pkg.sv | 37 +++
 rtl/yarp_arb2_pick.sv | 27 ++
 rtl/yarp_mem_arb.sv | 124 ++++++++++++
 tb/tb_yarp_mem_arb.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yarp_mem_arb_pkg.sv
// Shared types for the YARP memory-port arbiter: FSM states, owners, the
// latched memory request, and the access-size encodings used by the load/store path.
package yarp_mem_arb_pkg;

    localparam logic [1:0] BYTE      = 2'b00;
    localparam logic [1:0] HALF_WORD = 2'b01;
    localparam logic [1:0] WORD      = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RSP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } mem_req_t;

    // A fetch is always a word read with no write data.
    function automatic mem_req_t instr_to_mem(input logic [31:0] addr);
        mem_req_t r;
        r.addr  = addr;
        r.wr    = 1'b0;
        r.size  = WORD;
        r.wdata = 32'h0;
        return r;
    endfunction

endpackage

// File: rtl/yarp_arb2_pick.sv
// Combinational two-requester picker: req[0] = fetch, req[1] = load/store.
// On a tie, data wins when DATA_PRIO is set, otherwise whoever was not served last wins.
module yarp_arb2_pick
    import yarp_mem_arb_pkg::*;
#(
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic [1:0] req,
    input  arb_owner_t last_owner,
    output arb_owner_t winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = OWN_INSTR;
        if (req == 2'b11) begin
            if (DATA_PRIO)
                winner = OWN_DATA;
            else
                winner = (last_owner == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
        end else if (req[1]) begin
            winner = OWN_DATA;
        end
    end

endmodule

// File: rtl/yarp_mem_arb.sv
// Shares the single YARP memory port between instruction fetch and load/store.
// One outstanding transaction; grant and response are routed back to the owner only.
module yarp_mem_arb
    import yarp_mem_arb_pkg::*;
#(
    parameter bit          DATA_PRIO      = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,

    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_wr_i,
    input  logic [1:0]  data_byte_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,

    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_wr_o,
    output logic [1:0]  mem_byte_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    output logic        bus_err_o
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    arb_state_t  state;
    arb_owner_t  owner;
    arb_owner_t  last_owner;
    logic [15:0] cnt;

    arb_owner_t  pick_winner;
    logic        pick_valid;
    mem_req_t    pick_req;

    logic        in_req;
    logic        in_rsp;
    logic        gnt_fire;
    logic        rsp_timeout;
    logic        rsp_done;
    logic        launch;

    yarp_arb2_pick #(
        .DATA_PRIO (DATA_PRIO)
    ) u_pick (
        .req        ({data_req_i, instr_req_i}),
        .last_owner (last_owner),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    always_comb begin
        pick_req = instr_to_mem(instr_addr_i);
        if (pick_winner == OWN_DATA) begin
            pick_req.addr  = data_addr_i;
            pick_req.wr    = data_wr_i;
            pick_req.size  = data_byte_i;
            pick_req.wdata = data_wdata_i;
        end
    end

    assign in_req      = (state == ARB_REQ);
    assign in_rsp      = (state == ARB_RSP);
    assign gnt_fire    = in_req && mem_gnt_i;
    assign rsp_timeout = in_rsp && !mem_rvalid_i && (cnt == CNT_LAST);
    assign rsp_done    = in_rsp && (mem_rvalid_i || rsp_timeout);
    // Re-arbitrating in the completion cycle gives back-to-back accesses
    // with mem_req_o high again the cycle right after the response.
    assign launch      = pick_valid && ((state == ARB_IDLE) || rsp_done);

    assign instr_gnt_o    = gnt_fire && (owner == OWN_INSTR);
    assign data_gnt_o     = gnt_fire && (owner == OWN_DATA);
    assign instr_rvalid_o = rsp_done && (owner == OWN_INSTR);
    assign data_rvalid_o  = rsp_done && (owner == OWN_DATA);
    assign instr_rdata_o  = (in_rsp && mem_rvalid_i && owner == OWN_INSTR) ? mem_rdata_i : 32'h0;
    assign data_rdata_o   = (in_rsp && mem_rvalid_i && owner == OWN_DATA)  ? mem_rdata_i : 32'h0;
    assign bus_err_o      = rsp_timeout;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ARB_IDLE;
            owner       <= OWN_INSTR;
            last_owner  <= OWN_INSTR;
            cnt         <= 16'h0;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= 32'h0;
            mem_wr_o    <= 1'b0;
            mem_byte_o  <= 2'b00;
            mem_wdata_o <= 32'h0;
        end else if (launch) begin
            state       <= ARB_REQ;
            owner       <= pick_winner;
            last_owner  <= pick_winner;
            mem_req_o   <= 1'b1;
            mem_addr_o  <= pick_req.addr;
            mem_wr_o    <= pick_req.wr;
            mem_byte_o  <= pick_req.size;
            mem_wdata_o <= pick_req.wdata;
        end else if (rsp_done) begin
            state <= ARB_IDLE;
        end else if (gnt_fire) begin
            state     <= ARB_RSP;
            mem_req_o <= 1'b0;
            cnt       <= 16'h0;
        end else if (in_rsp) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_yarp_mem_arb.sv
// Bench for yarp_mem_arb: dut_a (data priority, short timeout) and dut_b (round-robin),
// sharing stimulus; a scoreboard queue holds the expected {is_data, rdata} responses.
module tb_yarp_mem_arb;
    import yarp_mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sel = 1'b0;

    logic        instr_req = 1'b0;
    logic [31:0] instr_addr = 32'h0;
    logic        data_req = 1'b0;
    logic [31:0] data_addr = 32'h0;
    logic        data_wr = 1'b0;
    logic [1:0]  data_byte = 2'b00;
    logic [31:0] data_wdata = 32'h0;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    logic        a_i_gnt, a_i_rvalid, a_d_gnt, a_d_rvalid, a_m_req, a_m_wr, a_bus_err;
    logic [31:0] a_i_rdata, a_d_rdata, a_m_addr, a_m_wdata;
    logic [1:0]  a_m_byte;
    logic        b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid, b_m_req, b_m_wr, b_bus_err;
    logic [31:0] b_i_rdata, b_d_rdata, b_m_addr, b_m_wdata;
    logic [1:0]  b_m_byte;

    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_wr, bus_err;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic [1:0]  m_byte;

    logic [32:0] exp_q[$];
    int          n_checks = 0;
    int          n_errs = 0;

    always #5 clk = ~clk;

    yarp_mem_arb #(.DATA_PRIO(1'b1), .TIMEOUT_CYCLES(4)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr),
        .instr_gnt_o(a_i_gnt), .instr_rvalid_o(a_i_rvalid), .instr_rdata_o(a_i_rdata),
        .data_req_i(data_req), .data_addr_i(data_addr), .data_wr_i(data_wr),
        .data_byte_i(data_byte), .data_wdata_i(data_wdata),
        .data_gnt_o(a_d_gnt), .data_rvalid_o(a_d_rvalid), .data_rdata_o(a_d_rdata),
        .mem_req_o(a_m_req), .mem_addr_o(a_m_addr), .mem_wr_o(a_m_wr),
        .mem_byte_o(a_m_byte), .mem_wdata_o(a_m_wdata),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .bus_err_o(a_bus_err)
    );

    yarp_mem_arb #(.DATA_PRIO(1'b0), .TIMEOUT_CYCLES(255)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr),
        .instr_gnt_o(b_i_gnt), .instr_rvalid_o(b_i_rvalid), .instr_rdata_o(b_i_rdata),
        .data_req_i(data_req), .data_addr_i(data_addr), .data_wr_i(data_wr),
        .data_byte_i(data_byte), .data_wdata_i(data_wdata),
        .data_gnt_o(b_d_gnt), .data_rvalid_o(b_d_rvalid), .data_rdata_o(b_d_rdata),
        .mem_req_o(b_m_req), .mem_addr_o(b_m_addr), .mem_wr_o(b_m_wr),
        .mem_byte_o(b_m_byte), .mem_wdata_o(b_m_wdata),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .bus_err_o(b_bus_err)
    );

    assign i_gnt    = sel ? b_i_gnt    : a_i_gnt;
    assign i_rvalid = sel ? b_i_rvalid : a_i_rvalid;
    assign i_rdata  = sel ? b_i_rdata  : a_i_rdata;
    assign d_gnt    = sel ? b_d_gnt    : a_d_gnt;
    assign d_rvalid = sel ? b_d_rvalid : a_d_rvalid;
    assign d_rdata  = sel ? b_d_rdata  : a_d_rdata;
    assign m_req    = sel ? b_m_req    : a_m_req;
    assign m_addr   = sel ? b_m_addr   : a_m_addr;
    assign m_wr     = sel ? b_m_wr     : a_m_wr;
    assign m_byte   = sel ? b_m_byte   : a_m_byte;
    assign m_wdata  = sel ? b_m_wdata  : a_m_wdata;
    assign bus_err  = sel ? b_bus_err  : a_bus_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Response monitor: every rvalid pops the scoreboard.
    logic [32:0] sb_e;
    always @(negedge clk) begin
        if (reset_n) begin
            if (i_gnt || d_gnt)
                check("gnt_one_hot", 32'(i_gnt && d_gnt), 32'h0);
            if (i_rvalid || d_rvalid) begin
                check("rvalid_one_hot", 32'(i_rvalid && d_rvalid), 32'h0);
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'({i_rvalid, d_rvalid}), 32'h0);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("rsp_owner", 32'(d_rvalid), 32'(sb_e[32]));
                    check("rsp_data", d_rvalid ? d_rdata : i_rdata, sb_e[31:0]);
                    check("rsp_other_rdata", d_rvalid ? i_rdata : d_rdata, 32'h0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        instr_req  = 1'b0;
        data_req   = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    // Waits (bounded) for mem_req_o, grants for one cycle, returns what was presented.
    task automatic mem_grant(output logic got_d, output logic [31:0] addr, output logic wr,
                             output logic [1:0] sz, output logic [31:0] wd);
        int n = 0;
        while (!m_req && n < 20) begin
            tick();
            n++;
        end
        check("grant_wait", 32'(m_req), 32'h1);
        mem_gnt = 1'b1;
        @(negedge clk);
        check("gnt_exactly_one", 32'(i_gnt ^ d_gnt), 32'h1);
        got_d = d_gnt;
        addr  = m_addr;
        wr    = m_wr;
        sz    = m_byte;
        wd    = m_wdata;
        tick();
        mem_gnt = 1'b0;
    endtask

    task automatic mem_respond(input int dly, input logic [31:0] rd);
        repeat (dly) tick();
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        @(negedge clk);
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        got_d, wr;
        logic [31:0] addr, wd;
        logic [1:0]  sz;
        logic [31:0] rd [4];
        logic [31:0] r1, r2;

        // Reset state
        do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_mem_req", 32'(m_req), 32'h0);
        check("rst_mem_fields", {m_addr[15:0], m_wdata[11:0], 1'b0, m_wr, m_byte}, 32'h0);
        check("rst_gnt_rvalid", 32'({i_gnt, d_gnt, i_rvalid, d_rvalid, bus_err}), 32'h0);
        check("rst_rdata", i_rdata | d_rdata, 32'h0);
        check("rst_state", 32'(dut_a.state), 32'(ARB_IDLE));
        tick();
        reset_n = 1'b1;

        // Round-robin, both held for 4 transactions: D, I, D, I
        sel        = 1'b1;
        instr_req  = 1'b1;
        instr_addr = {$urandom_range(0, 16'hFFFF), 2'b00} & 32'h0003_FFFC;
        data_req   = 1'b1;
        data_addr  = 32'h0008_0000 | ({$urandom_range(0, 16'hFFFF), 2'b00} & 32'h0003_FFFC);
        data_wr    = 1'b0;
        data_byte  = WORD;
        data_wdata = 32'h0;
        for (int k = 0; k < 4; k++) begin
            rd[k] = $urandom;
            exp_q.push_back({(k % 2 == 0), rd[k]});
            mem_grant(got_d, addr, wr, sz, wd);
            check("rr_owner", 32'(got_d), 32'(k % 2 == 0));
            check("rr_addr", addr, (k % 2 == 0) ? data_addr : instr_addr);
            if (k == 3) begin
                instr_req = 1'b0;
                data_req  = 1'b0;
            end
            mem_respond($urandom_range(0, 2), rd[k]);
        end
        repeat (2) tick();

        do_reset();
        sel = 1'b0;

        // Single fetch: gnt in cycle 1, rvalid in cycle 3
        instr_req  = 1'b1;
        instr_addr = 32'h0000_0100;
        @(negedge clk);
        check("t1_req_cycle0", 32'(m_req), 32'h0);
        tick();
        mem_grant(got_d, addr, wr, sz, wd);
        check("t1_owner", 32'(got_d), 32'h0);
        check("t1_addr", addr, 32'h0000_0100);
        check("t1_wr_byte", 32'({wr, sz}), 32'({1'b0, WORD}));
        check("t1_wdata", wd, 32'h0);
        check("t1_req_drop", 32'(m_req), 32'h0);
        instr_req = 1'b0;
        exp_q.push_back({1'b0, 32'h00A0_0093});
        mem_respond(1, 32'h00A0_0093);
        check("t1_idle_after", 32'(m_req), 32'h0);

        // Tie with data priority: store served first, then fetch back-to-back
        r1 = $urandom;
        r2 = $urandom;
        instr_req  = 1'b1;
        instr_addr = 32'h0000_0300;
        data_req   = 1'b1;
        data_addr  = 32'h0000_0200;
        data_wr    = 1'b1;
        data_byte  = HALF_WORD;
        data_wdata = 32'hCAFE_F00D;
        exp_q.push_back({1'b1, r1});
        exp_q.push_back({1'b0, r2});
        mem_grant(got_d, addr, wr, sz, wd);
        check("t2_first_owner", 32'(got_d), 32'h1);
        check("t2_first_addr", addr, 32'h0000_0200);
        check("t2_first_wr_byte", 32'({wr, sz}), 32'({1'b1, HALF_WORD}));
        check("t2_first_wdata", wd, 32'hCAFE_F00D);
        data_req = 1'b0;
        mem_respond(0, r1);
        check("t2_rearb_latency", 32'(m_req), 32'h1);
        mem_grant(got_d, addr, wr, sz, wd);
        check("t2_second_owner", 32'(got_d), 32'h0);
        check("t2_second_addr", addr, 32'h0000_0300);
        check("t2_second_wr_byte", 32'({wr, sz}), 32'({1'b0, WORD}));
        check("t2_second_wdata", wd, 32'h0);
        instr_req = 1'b0;
        mem_respond(2, r2);

        // Grant withheld 5 cycles: request and fields held stable
        data_req   = 1'b1;
        data_addr  = 32'h0000_0400;
        data_wr    = 1'b1;
        data_byte  = BYTE;
        data_wdata = 32'h5A5A_1234;
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_hold_req", 32'(m_req), 32'h1);
            check("t4_hold_addr", m_addr, 32'h0000_0400);
            check("t4_hold_wdata", m_wdata, 32'h5A5A_1234);
            check("t4_no_gnt", 32'(i_gnt | d_gnt), 32'h0);
            tick();
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        check("t4_gnt", 32'({i_gnt, d_gnt}), 32'h1);
        check("t4_req_at_gnt", 32'(m_req), 32'h1);
        check("t4_byte", 32'(m_byte), 32'(BYTE));
        tick();
        mem_gnt  = 1'b0;
        data_req = 1'b0;
        r1 = $urandom;
        exp_q.push_back({1'b1, r1});
        mem_respond(0, r1);

        // Timeout (TIMEOUT_CYCLES = 4): error response 4 cycles after the grant
        instr_req  = 1'b1;
        instr_addr = 32'h0000_0500;
        mem_grant(got_d, addr, wr, sz, wd);
        instr_req = 1'b0;
        exp_q.push_back({1'b0, 32'h0});
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("t5_bus_err", 32'(bus_err), 32'(k == 4));
            tick();
        end
        check("t5_idle_req", 32'(m_req), 32'h0);
        check("t5_state", 32'(dut_a.state), 32'(ARB_IDLE));
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_DEAD;
        @(negedge clk);
        check("t5_late_rvalid", 32'({i_rvalid, d_rvalid}), 32'h0);
        tick();
        mem_rvalid = 1'b0;

        // Reset during ARB_RSP discards the access
        instr_req  = 1'b1;
        instr_addr = 32'h0000_0600;
        mem_grant(got_d, addr, wr, sz, wd);
        instr_req = 1'b0;
        reset_n   = 1'b0;
        tick();
        reset_n    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        @(negedge clk);
        check("t6_no_rvalid", 32'({i_rvalid, d_rvalid}), 32'h0);
        check("t6_req", 32'(m_req), 32'h0);
        check("t6_state", 32'(dut_a.state), 32'(ARB_IDLE));
        tick();
        mem_rvalid = 1'b0;

        repeat (3) tick();
        check("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
